// File: rtl/seq_run_ctrl.sv
// rtl/seq_run_ctrl.sv - run controller for the 4-bit sequence generator
//
// Purpose: clears the generator, then advances it in FREE, COUNT or STEP
// mode, optionally stopping when the generator number equals a target.
//
// Ports:
//   CLK          clock, all state updates on rising edge
//   Reset        synchronous active-high reset
//   start        launch a run (sampled only in IDLE)
//   stop         abort the current run (RUN/STEP_WAIT only)
//   step_req     one-step request, STEP mode only
//   mode         00 FREE, 01 COUNT, 10 STEP, 11 treated as FREE
//   run_len      number of advances for COUNT mode
//   target       stop value for number
//   target_en    enable target match
//   number       current number from the generator
//   gen_clear    clear pulse to the generator
//   gen_advance  advance enable to the generator
//   busy         high in CLEAR, RUN, STEP_WAIT
//   done         one-cycle pulse at the end of a run
//   hit          sticky: run ended on target match
//   steps        advances issued in the current/last run
module seq_run_ctrl #(
  parameter int NUM_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic             stop,
  input  logic             step_req,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] run_len,
  input  logic [NUM_W-1:0] target,
  input  logic             target_en,
  input  logic [NUM_W-1:0] number,
  output logic             gen_clear,
  output logic             gen_advance,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic [CNT_W-1:0] steps
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_STEP_WAIT,
    S_DONE
  } state_t;

  localparam logic [1:0]     MODE_FREE  = 2'b00;
  localparam logic [1:0]     MODE_COUNT = 2'b01;
  localparam logic [1:0]     MODE_STEP  = 2'b10;
  localparam logic [CNT_W:0] ONE_WIDE   = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [CNT_W-1:0]   run_len_q, run_len_d;
  logic [NUM_W-1:0]   target_q, target_d;
  logic               target_en_q, target_en_d;
  logic [CNT_W-1:0]   steps_q, steps_d;
  logic               hit_q, hit_d;
  logic               active;
  logic               match;
  logic               adv_ok;

  // Match is only meaningful while a run can advance; it looks at the value
  // the generator shows before any advance issued in this same cycle.
  assign active = (state_q == S_RUN) || (state_q == S_STEP_WAIT);
  assign match  = active && target_en_q && (number == target_q);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    run_len_d   = run_len_q;
    target_d    = target_q;
    target_en_d = target_en_q;
    steps_d     = steps_q;
    hit_d       = hit_q;
    gen_clear   = 1'b0;
    gen_advance = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    adv_ok      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // Reserved mode 11 is stored as FREE so later decodes stay simple.
          mode_d      = (mode == 2'b11) ? MODE_FREE : mode;
          run_len_d   = run_len;
          target_d    = target;
          target_en_d = target_en;
          hit_d       = 1'b0;
          state_d     = S_CLEAR;
        end
      end

      S_CLEAR: begin
        gen_clear = 1'b1;
        busy      = 1'b1;
        steps_d   = '0;
        if ((mode_q == MODE_COUNT) && (run_len_q == '0)) begin
          state_d = S_DONE;
        end else if (mode_q == MODE_STEP) begin
          state_d = S_STEP_WAIT;
        end else begin
          state_d = S_RUN;
        end
      end

      S_RUN, S_STEP_WAIT: begin
        busy   = 1'b1;
        adv_ok = (state_q == S_RUN) || step_req;
        // Priority: stop, then match, then length completion, then advance.
        if (stop) begin
          state_d = S_DONE;
        end else if (match) begin
          hit_d   = 1'b1;
          state_d = S_DONE;
        end else if (adv_ok) begin
          gen_advance = 1'b1;
          steps_d     = (steps_q == '1) ? steps_q : steps_q + ONE_CNT;
          if ((mode_q == MODE_COUNT) &&
              (({1'b0, steps_q} + ONE_WIDE) == {1'b0, run_len_q})) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Generator controls and done must be quiet for the whole reset cycle,
    // whatever state the register happens to hold.
    if (Reset) begin
      gen_clear   = 1'b0;
      gen_advance = 1'b0;
      done        = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      mode_q      <= MODE_FREE;
      run_len_q   <= '0;
      target_q    <= '0;
      target_en_q <= 1'b0;
      steps_q     <= '0;
      hit_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      run_len_q   <= run_len_d;
      target_q    <= target_d;
      target_en_q <= target_en_d;
      steps_q     <= steps_d;
      hit_q       <= hit_d;
    end
  end

  assign steps = steps_q;
  assign hit   = hit_q;

endmodule
